// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sequencer
// Description : Instruction decoder and run-control sequencer for the 4-bit
//               accumulator CPU datapath. Decodes instr[7:4] and the carry
//               flag into selector/load controls and gates execution through
//               an IDLE / RUN / STEP / HALT state machine.
// Optional    : SEQ_BREAKPOINT_EN - enables the PC breakpoint comparator and
//               its bp_armed flag. Undefined: bp inputs ignored, bp_hit = 0.
// Ports       : clk, reset (sync, active-high)
//               run (level), step_req (pulse), instr[7:0], cf
//               address[3:0], bp_addr[3:0], bp_valid
//               select_a, select_b, load0..load3, cpu_en, step_ack, bp_hit,
//               halted, state[1:0], instr_count[7:0]
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       step_req,
  input  logic [7:0] instr,
  input  logic       cf,
  input  logic [3:0] address,
  input  logic [3:0] bp_addr,
  input  logic       bp_valid,
  output logic       select_a,
  output logic       select_b,
  output logic       load0,
  output logic       load1,
  output logic       load2,
  output logic       load3,
  output logic       cpu_en,
  output logic       step_ack,
  output logic       bp_hit,
  output logic       halted,
  output logic [1:0] state,
  output logic [7:0] instr_count
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_STEP = 2'b10;
  localparam logic [1:0] ST_HALT = 2'b11;

  localparam logic [3:0] OP_HLT  = 4'b1000;

  logic [1:0] state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [3:0] opcode;
  logic       is_hlt;
  logic       bp_stop;
  logic [1:0] sel_dec;   // {select_b, select_a}
  logic [3:0] dest_dec;  // one-hot {PC, C, B, A}

  assign opcode = instr[7:4];
  assign is_hlt = (opcode == OP_HLT);

  // Opcode decode; unlisted opcodes are NOPs that still commit.
  always_comb begin
    sel_dec  = 2'b00;
    dest_dec = 4'b0000;
    case (opcode)
      4'b0000: begin sel_dec = 2'b00; dest_dec = 4'b0001; end
      4'b0101: begin sel_dec = 2'b01; dest_dec = 4'b0010; end
      4'b0011: begin sel_dec = 2'b11; dest_dec = 4'b0001; end
      4'b0111: begin sel_dec = 2'b11; dest_dec = 4'b0010; end
      4'b0001: begin sel_dec = 2'b01; dest_dec = 4'b0001; end
      4'b0100: begin sel_dec = 2'b00; dest_dec = 4'b0010; end
      4'b0010: begin sel_dec = 2'b10; dest_dec = 4'b0001; end
      4'b0110: begin sel_dec = 2'b10; dest_dec = 4'b0010; end
      4'b1001: begin sel_dec = 2'b01; dest_dec = 4'b0100; end
      4'b1011: begin sel_dec = 2'b11; dest_dec = 4'b0100; end
      4'b1111: begin sel_dec = 2'b11; dest_dec = 4'b1000; end
      // JNC: jump only when the previous instruction left no carry
      4'b1110: begin sel_dec = 2'b11; dest_dec = {~cf, 3'b000}; end
      default: begin sel_dec = 2'b00; dest_dec = 4'b0000; end
    endcase
  end

`ifdef SEQ_BREAKPOINT_EN
  // Low for the first RUN cycle after any entry, so resuming from a
  // breakpoint executes the instruction that stopped the run.
  logic bp_armed_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bp_armed_q <= 1'b0;
    end else begin
      bp_armed_q <= (state_q == ST_RUN);
    end
  end

  // HLT takes precedence over a breakpoint at the same address.
  assign bp_stop = !reset && (state_q == ST_RUN) && !is_hlt && bp_valid &&
                   (address == bp_addr) && bp_armed_q;
`else
  logic unused_bp;
  assign unused_bp = ^{address, bp_addr, bp_valid};
  assign bp_stop   = 1'b0;
`endif

  logic unused_imm;
  assign unused_imm = ^instr[3:0];

  // Reset gates every commit-side output so nothing commits in the reset cycle.
  assign cpu_en   = !reset && ((state_q == ST_RUN) || (state_q == ST_STEP)) &&
                    !is_hlt && !bp_stop;
  assign step_ack = !reset && (state_q == ST_STEP);
  assign bp_hit   = bp_stop;
  assign halted   = (state_q == ST_HALT);

  assign {select_b, select_a}        = reset ? 2'b00 : sel_dec;
  assign {load3, load2, load1, load0} = cpu_en ? dest_dec : 4'b0000;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (run)           state_d = ST_RUN;
        else if (step_req) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (is_hlt)       state_d = ST_HALT;
        else if (bp_stop) state_d = ST_IDLE;
        else if (!run)    state_d = ST_IDLE;
      end
      ST_STEP: begin
        state_d = is_hlt ? ST_HALT : ST_IDLE;
      end
      default: state_d = ST_HALT;
    endcase
  end

  assign count_d = count_q + {7'b0000000, cpu_en};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= 8'h00;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign state       = state_q;
  assign instr_count = count_q;

endmodule
`default_nettype wire

// File: doc/cpu_sequencer.md
# cpu_sequencer

Instruction decoder and run-control sequencer for the 4-bit accumulator CPU datapath. It decodes `instr[7:4]` and the carry flag into the data-selector and register-load controls (`select_a`, `select_b`, `load0`..`load3`), which are currently driven as free inputs. It also gates datapath execution through a run / single-step / halt state machine. The datapath commits one instruction per cycle in which `cpu_en` is high, and holds every register otherwise.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- `run`  in  1  level; free-run enable.
- `step_req`  in  1  single-cycle pulse; execute one instruction from IDLE.
- `instr`  in  8  current instruction from program memory; opcode `instr[7:4]`.
- `cf`  in  1  datapath carry flag (value committed by the previous instruction).
- `address`  in  4  datapath PC, used for breakpoint compare.
- `bp_addr`  in  4  breakpoint address.
- `bp_valid`  in  1  breakpoint enable.
- `select_a`, `select_b`  out  1 each  selector code `{select_b,select_a}`: 00=A, 01=B, 10=C, 11=zero.
- `load0`..`load3`  out  1 each  load A, B, C, PC from the ALU.
- `cpu_en`  out  1  datapath commit enable.
- `step_ack`  out  1  one-cycle pulse; stepped instruction commits this cycle.
- `bp_hit`  out  1  one-cycle pulse on breakpoint stop.
- `halted`  out  1  high in HALT.
- `state`  out  2  IDLE=00, RUN=01, STEP=10, HALT=11.
- `instr_count`  out  8  committed-instruction counter.

## Operation
- Decode is combinational from `instr[7:4]` and `cf`. Loads are gated by `cpu_en`; selects are not gated.
  - 0000 ADD A,Im: sel 00, `load0`.
  - 0101 ADD B,Im: sel 01, `load1`.
  - 0011 MOV A,Im: sel 11, `load0`.
  - 0111 MOV B,Im: sel 11, `load1`.
  - 0001 MOV A,B: sel 01, `load0`.
  - 0100 MOV B,A: sel 00, `load1`.
  - 0010 MOV A,C: sel 10, `load0`.
  - 0110 MOV B,C: sel 10, `load1`.
  - 1001 OUT B: sel 01, `load2`.
  - 1011 OUT Im: sel 11, `load2`.
  - 1111 JMP Im: sel 11, `load3`.
  - 1110 JNC Im: sel 11, `load3` = ~`cf`.
  - 1000 HLT: no loads, `cpu_en`=0.
  - All other opcodes: NOP; sel 00, no loads, still commits (PC+1, carry flag updated).
- `cpu_en` = (state RUN or STEP) and not HLT and not breakpoint stop.
- IDLE:
  - `run`=1 -> RUN.
  - Else `step_req`=1 -> STEP.
  - `run` has priority over `step_req`.
- RUN:
  - HLT -> HALT.
  - Else breakpoint stop -> IDLE.
  - Else `run`=0 -> IDLE, but the current instruction still commits.
  - Otherwise stay in RUN.
- STEP:
  - `step_ack`=1.
  - HLT -> HALT.
  - Otherwise commit one instruction and return to IDLE.
- HALT: all loads and `cpu_en` are 0. Exit only on `reset`. `run` and `step_req` are ignored.
- `step_req` outside IDLE is ignored and not queued.
- `instr_count` increments when `cpu_en`=1 and wraps 255 -> 0.

## Timing
- Reset values:
  - `state`=IDLE; `instr_count`=0.
  - `cpu_en`, `step_ack`, `bp_hit`, `halted` = 0.
  - All loads = 0; selects = 00.
- Reset asserted mid-RUN or mid-STEP: next state is IDLE, nothing commits in the reset cycle, and any in-flight step is dropped without `step_ack`.
- `run` rising in IDLE: first commit is in the next cycle, i.e. 1 cycle of latency.
- `step_req` pulse: `step_ack` and the single commit occur in the next cycle.
- HLT or breakpoint cycle: `cpu_en`=0, so PC holds at the stopping address.
- `halted` goes high the cycle after HLT is decoded.

## Configuration
- `SEQ_BREAKPOINT_EN` defined:
  - In RUN, when `bp_valid` and `address`==`bp_addr` and the `bp_armed` flag is set, the cycle is a breakpoint stop: `cpu_en`=0, `bp_hit`=1, next state IDLE.
  - `bp_armed` clears on every entry to RUN and sets after the first RUN cycle. Resuming from a breakpoint therefore executes the breakpointed instruction.
  - STEP never matches the breakpoint.
- `SEQ_BREAKPOINT_EN` undefined:
  - `bp_addr`, `bp_valid`, `address` are ignored and `bp_hit` is tied to 0.
  - No `bp_armed` register is built.

## Test plan
- Reset mid-RUN (`run`=1, instr 0x03):
  - Reset asserted -> next cycle `state`=00, `cpu_en`=0, `load0`=0, `instr_count`=0.
- Decode sweep in RUN with `cf`=0, then `cf`=1:
  - Loads and selects match the Operation list for all 16 opcodes.
  - 0xE5 with `cf`=0 -> `load3`=1; 0xE5 with `cf`=1 -> `load3`=0.
- IDLE, pulse `step_req` with instr 0x57:
  - Next cycle `state`=10, `step_ack`=1, `load1`=1, sel 01.
  - Following cycle `state`=00, `instr_count`=1.
- RUN, instr 0x80 (HLT):
  - That cycle `cpu_en`=0.
  - Next cycle `halted`=1, `state`=11.
  - `run` toggles and `step_req` pulses produce no change until `reset`.
- `SEQ_BREAKPOINT_EN` defined, `bp_addr`=4, `bp_valid`=1, RUN from `address` 0:
  - Commits at addresses 0-3.
  - At `address`=4: `bp_hit`=1, `cpu_en`=0, then IDLE.
  - Re-assert `run` -> address 4 commits, no second hit.
- Counter wrap:
  - 256 NOP (0xA0) commits in RUN -> `instr_count` goes 255 -> 0.
